// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
//   Fetch-stage program counter and next-PC generator.  Holds the current
//   fetch PC, offers it to the I-cache with a valid/ready handshake and picks
//   the next PC from trap vector, EX redirect, ID jump or sequential step.
//
//   Optional feature macro: PCG_RAS_EN adds a circular return-address stack.
//
// Parameters
//   PC_WIDTH      width of every PC/address bus
//   RESET_VECTOR  PC loaded on reset
//   C_EXT         1: +2 step allowed, 2-byte alignment; 0: +4 only, 4-byte
//   RAS_DEPTH     RAS entries (power of 2, >= 2), PCG_RAS_EN only
//
// Ports
//   clk, reset                 clock (posedge), async active-high reset
//   stall                      hold PC; ID jumps ignored while set
//   fetch_ready / fetch_valid  I-cache handshake for pc_out
//   pc_out                     registered fetch PC
//   inst_compressed            instruction at pc_out is 16-bit
//   id_jump_valid/_pc          ID-stage redirect
//   ex_redirect_valid/_pc      EX-stage redirect (flush)
//   trap_valid/trap_pc         trap / mret redirect (flush)
//   redirect_taken             1-cycle pulse after a redirect is loaded
//   misaligned                 1-cycle pulse: loaded target had low bits set
//   ras_push/ras_pop/ras_push_addr/ras_top/ras_empty   (PCG_RAS_EN only)
// ---------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int                  PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  C_EXT        = 1,
    parameter int                  RAS_DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic                inst_compressed,
    input  logic                id_jump_valid,
    input  logic [PC_WIDTH-1:0] id_jump_pc,
    input  logic                ex_redirect_valid,
    input  logic [PC_WIDTH-1:0] ex_redirect_pc,
    input  logic                trap_valid,
    input  logic [PC_WIDTH-1:0] trap_pc,
`ifdef PCG_RAS_EN
    input  logic                ras_push,
    input  logic                ras_pop,
    input  logic [PC_WIDTH-1:0] ras_push_addr,
    output logic [PC_WIDTH-1:0] ras_top,
    output logic                ras_empty,
`endif
    output logic                redirect_taken,
    output logic                misaligned
);

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [PC_WIDTH-1:0] LOW_BITS = (C_EXT != 0) ? PC_WIDTH'(1) : PC_WIDTH'(3);

    logic                load_redirect;
    logic                advance;
    logic [PC_WIDTH-1:0] raw_target;
    logic [PC_WIDTH-1:0] step;
    logic [PC_WIDTH-1:0] next_pc;

    always_comb begin
        load_redirect = 1'b0;
        advance       = 1'b0;
        raw_target    = '0;
        step          = (C_EXT != 0 && inst_compressed) ? PC_WIDTH'(2) : PC_WIDTH'(4);
        if (trap_valid) begin
            load_redirect = 1'b1;
            raw_target    = trap_pc;
        end else if (ex_redirect_valid) begin
            load_redirect = 1'b1;
            raw_target    = ex_redirect_pc;
        end else if (id_jump_valid && !stall) begin
            load_redirect = 1'b1;
            raw_target    = id_jump_pc;
        end else if (fetch_valid && fetch_ready && !stall) begin
            advance = 1'b1;
        end

        if (load_redirect)
            next_pc = raw_target & ~LOW_BITS;
        else if (advance)
            next_pc = pc_out + step;
        else
            next_pc = pc_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out         <= RESET_VECTOR;
            fetch_valid    <= 1'b0;
            redirect_taken <= 1'b0;
            misaligned     <= 1'b0;
        end else begin
            pc_out         <= next_pc;
            fetch_valid    <= 1'b1;
            redirect_taken <= load_redirect;
            misaligned     <= load_redirect && ((raw_target & LOW_BITS) != '0);
        end
    end

`ifdef PCG_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    // ptr is the next write slot; the top entry sits at ptr-1.
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]       ras_ptr;
    logic [CW-1:0]       ras_count;
    logic [PW-1:0]       top_idx;
    logic [PC_WIDTH-1:0] push_aligned;

    assign top_idx      = ras_ptr - 1'b1;
    assign push_aligned = ras_push_addr & ~LOW_BITS;
    assign ras_empty    = (ras_count == '0);
    assign ras_top      = ras_empty ? '0 : ras_mem[top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (trap_valid) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (ras_push && !(ras_pop && !ras_empty)) begin
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_count != CW'(RAS_DEPTH))
                ras_count <= ras_count + 1'b1;
        end else if (ras_pop && !ras_push && !ras_empty) begin
            ras_ptr   <= ras_ptr - 1'b1;
            ras_count <= ras_count - 1'b1;
        end
    end

    // Entry storage needs no reset: it is never visible while count is zero.
    always_ff @(posedge clk) begin
        if (!trap_valid && ras_push) begin
            if (ras_pop && !ras_empty)
                ras_mem[top_idx] <= push_aligned;   // tail call: replace top
            else
                ras_mem[ras_ptr] <= push_aligned;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [63:0] pc_out;
    logic        inst_compressed;
    logic        id_jump_valid;
    logic [63:0] id_jump_pc;
    logic        ex_redirect_valid;
    logic [63:0] ex_redirect_pc;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        redirect_taken;
    logic        misaligned;
`ifdef PCG_RAS_EN
    logic        ras_push;
    logic        ras_pop;
    logic [63:0] ras_push_addr;
    logic [63:0] ras_top;
    logic        ras_empty;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .PC_WIDTH(64), .RESET_VECTOR(64'h0), .C_EXT(1), .RAS_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .inst_compressed(inst_compressed),
        .id_jump_valid(id_jump_valid), .id_jump_pc(id_jump_pc),
        .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
`ifdef PCG_RAS_EN
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_push_addr(ras_push_addr),
        .ras_top(ras_top), .ras_empty(ras_empty),
`endif
        .redirect_taken(redirect_taken), .misaligned(misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; fetch_ready = 0; inst_compressed = 0;
        id_jump_valid = 0; id_jump_pc = '0;
        ex_redirect_valid = 0; ex_redirect_pc = '0;
        trap_valid = 0; trap_pc = '0;
`ifdef PCG_RAS_EN
        ras_push = 0; ras_pop = 0; ras_push_addr = '0;
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        checks++; if (pc_out !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
        checks++; if ({redirect_taken, misaligned} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {redirect_taken, misaligned}); end
        reset = 0;
        fetch_ready = 1;
        tick();
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 64'h0) begin failures++; $display("FAIL first_edge valid=%b pc=%h exp valid=1 pc=0", fetch_valid, pc_out); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc [3] = '{64'h102, 64'h106, 64'h108};
        logic        comp   [3] = '{1'b1, 1'b0, 1'b1};
        clear_inputs();
        ex_redirect_valid = 1; ex_redirect_pc = 64'h100;
        tick();
        checks++; if (pc_out !== 64'h100) begin failures++; $display("FAIL seq_load got=%h exp=100", pc_out); end
        ex_redirect_valid = 0;
        fetch_ready = 1;
        for (int i = 0; i < 3; i++) begin
            inst_compressed = comp[i];
            tick();
            checks++; if (pc_out !== exp_pc[i] || redirect_taken !== 1'b0) begin
                failures++; $display("FAIL seq_step%0d pc=%h rt=%b exp pc=%h rt=0", i, pc_out, redirect_taken, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        stall = 1; fetch_ready = 1;
        id_jump_valid = 1; id_jump_pc = 64'h200;
        tick();
        checks++; if (pc_out !== 64'h108 || redirect_taken !== 1'b0) begin failures++; $display("FAIL stall_hold pc=%h rt=%b exp pc=108 rt=0", pc_out, redirect_taken); end
        ex_redirect_valid = 1; ex_redirect_pc = 64'h300;
        tick();
        checks++; if (pc_out !== 64'h300 || redirect_taken !== 1'b1) begin failures++; $display("FAIL stall_ex pc=%h rt=%b exp pc=300 rt=1", pc_out, redirect_taken); end
        ex_redirect_valid = 0; id_jump_valid = 0;
        tick();
        checks++; if (pc_out !== 64'h300 || redirect_taken !== 1'b0) begin failures++; $display("FAIL stall_pulse pc=%h rt=%b exp pc=300 rt=0", pc_out, redirect_taken); end
    endtask

    task automatic test_priority();
        clear_inputs();
        trap_valid = 1; trap_pc = 64'h80;
        ex_redirect_valid = 1; ex_redirect_pc = 64'h300;
        id_jump_valid = 1; id_jump_pc = 64'h200;
        tick();
        checks++; if (pc_out !== 64'h80 || redirect_taken !== 1'b1) begin failures++; $display("FAIL prio_trap pc=%h rt=%b exp pc=80 rt=1", pc_out, redirect_taken); end
        trap_valid = 0;
        ex_redirect_pc = 64'h301;
        tick();
        checks++; if (pc_out !== 64'h300 || misaligned !== 1'b1) begin failures++; $display("FAIL prio_ex_mis pc=%h mis=%b exp pc=300 mis=1", pc_out, misaligned); end
        clear_inputs();
        tick();
        checks++; if (pc_out !== 64'h300 || misaligned !== 1'b0 || redirect_taken !== 1'b0) begin failures++; $display("FAIL mis_pulse pc=%h mis=%b rt=%b exp pc=300 mis=0 rt=0", pc_out, misaligned, redirect_taken); end
    endtask

    task automatic test_id_jump();
        clear_inputs();
        fetch_ready = 1;
        id_jump_valid = 1; id_jump_pc = 64'h206;
        tick();
        checks++; if (pc_out !== 64'h206 || redirect_taken !== 1'b1 || misaligned !== 1'b0) begin failures++; $display("FAIL id_jump pc=%h rt=%b mis=%b exp pc=206 rt=1 mis=0", pc_out, redirect_taken, misaligned); end
    endtask

    task automatic test_wrap();
        clear_inputs();
        ex_redirect_valid = 1; ex_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        ex_redirect_valid = 0;
        tick();
        checks++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_hold got=%h exp=fffffffffffffffc", pc_out); end
        fetch_ready = 1;
        tick();
        checks++; if (pc_out !== 64'h0 || misaligned !== 1'b0 || redirect_taken !== 1'b0) begin failures++; $display("FAIL wrap pc=%h mis=%b rt=%b exp pc=0 mis=0 rt=0", pc_out, misaligned, redirect_taken); end
        fetch_ready = 0;
        tick();
        checks++; if (pc_out !== 64'h0) begin failures++; $display("FAIL wrap_ready0 got=%h exp=0", pc_out); end
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        ex_redirect_valid = 1; ex_redirect_pc = 64'h500;
        tick();
        ex_redirect_valid = 0;
        trap_valid = 1; trap_pc = 64'h400;
        #2;
        reset = 1;
        #1;
        checks++; if (pc_out !== 64'h0 || fetch_valid !== 1'b0 || redirect_taken !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h v=%b rt=%b exp pc=0 v=0 rt=0", pc_out, fetch_valid, redirect_taken); end
        tick();
        clear_inputs();
        reset = 0;
        tick();
        checks++; if (pc_out !== 64'h0 || fetch_valid !== 1'b1 || redirect_taken !== 1'b0) begin failures++; $display("FAIL reset_release pc=%h v=%b rt=%b exp pc=0 v=1 rt=0", pc_out, fetch_valid, redirect_taken); end
    endtask

`ifdef PCG_RAS_EN
    task automatic test_ras();
        clear_inputs();
        checks++; if (ras_empty !== 1'b1 || ras_top !== 64'h0) begin failures++; $display("FAIL ras_init empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
        for (int i = 1; i <= 9; i++) begin
            ras_push = 1; ras_push_addr = 64'h1000 + 64'(i * 16);
            tick();
        end
        ras_push = 0;
        checks++; if (ras_empty !== 1'b0 || ras_top !== 64'h1090) begin failures++; $display("FAIL ras_full empty=%b top=%h exp empty=0 top=1090", ras_empty, ras_top); end
        for (int i = 9; i >= 2; i--) begin
            checks++; if (ras_top !== 64'h1000 + 64'(i * 16)) begin failures++; $display("FAIL ras_pop_top%0d got=%h exp=%h", i, ras_top, 64'h1000 + 64'(i * 16)); end
            ras_pop = 1;
            tick();
            ras_pop = 0;
        end
        checks++; if (ras_empty !== 1'b1 || ras_top !== 64'h0) begin failures++; $display("FAIL ras_drained empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
        ras_pop = 1;
        tick();
        ras_pop = 0;
        checks++; if (ras_empty !== 1'b1 || ras_top !== 64'h0) begin failures++; $display("FAIL ras_pop_empty empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
        ras_push = 1; ras_push_addr = 64'h2001;
        tick();
        checks++; if (ras_top !== 64'h2000) begin failures++; $display("FAIL ras_align got=%h exp=2000", ras_top); end
        ras_pop = 1; ras_push_addr = 64'h3000;
        tick();
        ras_push = 0;
        checks++; if (ras_top !== 64'h3000 || ras_empty !== 1'b0) begin failures++; $display("FAIL ras_tail top=%h empty=%b exp top=3000 empty=0", ras_top, ras_empty); end
        tick();
        ras_pop = 0;
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ras_tail_count empty=%b exp=1", ras_empty); end
        ras_push = 1; ras_push_addr = 64'h4000;
        tick();
        ras_push = 0;
        trap_valid = 1; trap_pc = 64'h80;
        tick();
        trap_valid = 0;
        checks++; if (ras_empty !== 1'b1 || ras_top !== 64'h0) begin failures++; $display("FAIL ras_trap_clear empty=%b top=%h exp empty=1 top=0", ras_empty, ras_top); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_priority();
        test_id_jump();
        test_wrap();
        test_mid_reset();
`ifdef PCG_RAS_EN
        test_ras();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
